// File: rtl/brom_arbiter_if.sv
// Requester-side and boot-ROM-side handshake bundle for brom_arbiter.
// master = arbiter view, slave = requesters plus boot ROM view.
interface brom_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        resp_valid_o;
    logic                      resp_err_o;
    logic [DATA_W-1:0]         resp_data_o;
    logic                      brom_req_valid_o;
    logic [ADDR_W-1:0]         brom_req_address_o;
    logic                      brom_ready_i;
    logic [DATA_W-1:0]         brom_resp_data_i;
    logic                      brom_resp_valid_i;

    modport master (
        input  req_valid_i, req_addr_i, brom_ready_i, brom_resp_data_i, brom_resp_valid_i,
        output req_ready_o, resp_valid_o, resp_err_o, resp_data_o,
               brom_req_valid_o, brom_req_address_o
    );

    modport slave (
        output req_valid_i, req_addr_i, brom_ready_i, brom_resp_data_i, brom_resp_valid_i,
        input  req_ready_o, resp_valid_o, resp_err_o, resp_data_o,
               brom_req_valid_o, brom_req_address_o
    );
endinterface

// File: rtl/brom_arbiter.sv
// Round-robin arbiter sharing the boot ROM among NUM_REQ requesters, one transaction in flight.
// Response returns one cycle after the ROM pulse; a watchdog turns a lost response into an error completion.
module brom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    brom_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                bvalid_q, bvalid_d;
    logic [ADDR_W-1:0]   baddr_q, baddr_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic                rerr_q, rerr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  ready_vec;

    // Search starts just after the last served requester so nobody starves.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!pick_found && bus.req_valid_i[(int'(rr_ptr_q) + off) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (!rst && state_q == S_IDLE && bus.brom_ready_i && pick_found) begin
            ready_vec = NUM_REQ'(1) << pick_idx;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        timer_d  = timer_q;
        bvalid_d = bvalid_q;
        baddr_d  = baddr_q;
        rvalid_d = '0;
        rerr_d   = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (|ready_vec) begin
                    state_d  = S_ISSUE;
                    grant_d  = pick_idx;
                    baddr_d  = bus.req_addr_i[int'(pick_idx) * ADDR_W +: ADDR_W];
                    bvalid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.brom_ready_i && bvalid_q) begin
                    state_d  = S_WAIT;
                    bvalid_d = 1'b0;
                    timer_d  = '0;
                end
            end
            S_WAIT: begin
                // A response landing on the last watchdog cycle still counts as good.
                if (bus.brom_resp_valid_i) begin
                    state_d  = S_RESP;
                    rdata_d  = bus.brom_resp_data_i;
                    rvalid_d = NUM_REQ'(1) << grant_q;
                end else if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
                    state_d  = S_RESP;
                    rdata_d  = '0;
                    rvalid_d = NUM_REQ'(1) << grant_q;
                    rerr_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                rr_ptr_d = grant_q;
                state_d  = rerr_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (bus.brom_ready_i && !bus.brom_resp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            grant_q  <= '0;
            timer_q  <= '0;
            bvalid_q <= 1'b0;
            baddr_q  <= '0;
            rvalid_q <= '0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            timer_q  <= timer_d;
            bvalid_q <= bvalid_d;
            baddr_q  <= baddr_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.req_ready_o        = ready_vec;
    assign bus.resp_valid_o       = rvalid_q;
    assign bus.resp_err_o         = rerr_q;
    assign bus.resp_data_o        = rdata_q;
    assign bus.brom_req_valid_o   = bvalid_q;
    assign bus.brom_req_address_o = baddr_q;
endmodule

// File: tb/tb_brom_arbiter.sv
// Bench for brom_arbiter: directed scenarios then random traffic, checked every cycle
// against a timestamp-based transaction model and a behavioural boot ROM.
module tb_brom_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    brom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();
    brom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT))
        dut (.clk(clk), .rst(rst), .bus(bif));

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus controls
    logic [NUM_REQ-1:0] rv;
    logic [ADDR_W-1:0]  ra [NUM_REQ];
    bit rdy, force_resp, drop_on_accept, rand_mode;
    // boot ROM model
    int rom_lat, rom_due;
    bit rom_mute, rom_rand;
    logic [DATA_W-1:0] rom_data;
    // transaction model
    int cyc, acc_cyc, hs_cyc, done_cyc, m_grant, m_ptr;
    bit tx_active, draining, done_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] done_data;
    // observations
    int last_acc_cyc, last_acc_idx, first_bv_cyc, last_pulse_cyc, pulses;
    logic [ADDR_W-1:0] first_bv_addr;
    logic [DATA_W-1:0] last_pulse_data;
    logic [NUM_REQ-1:0] last_pulse_vec;
    bit last_pulse_err;
    int grants[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 1; k <= NUM_REQ; k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic clear_obs();
        last_acc_cyc = -1; last_acc_idx = -1; first_bv_cyc = -1;
        last_pulse_cyc = -1; pulses = 0; grants.delete();
    endtask

    task automatic one_cycle();
        logic [NUM_REQ-1:0] exp_rdy, exp_rv;
        logic exp_bv, exp_err, resp_in, rom_fire;
        int w;
        if (rand_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rv[i]) begin
                    ra[i] = ADDR_W'($urandom);
                    if ($urandom_range(0, 2) == 0) rv[i] = 1'b1;
                end
            end
            rdy = ($urandom_range(0, 4) != 0);
            force_resp = ($urandom_range(0, 19) == 0);
        end
        rom_fire = !rom_mute && (cyc == rom_due);
        resp_in  = rom_fire || force_resp;
        bif.req_valid_i = rv;
        for (int i = 0; i < NUM_REQ; i++) bif.req_addr_i[i*ADDR_W +: ADDR_W] = ra[i];
        bif.brom_ready_i      = rdy;
        bif.brom_resp_valid_i = resp_in;
        bif.brom_resp_data_i  = rom_fire ? rom_data : DATA_W'($urandom);
        force_resp = 1'b0;
        #2;
        exp_rdy = '0; w = -1;
        if (!rst && !tx_active && !draining && rdy) begin
            w = rr_pick(rv, m_ptr);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        exp_bv = tx_active && hs_cyc < 0 && cyc > acc_cyc;
        exp_rv = '0; exp_err = 1'b0;
        if (tx_active && cyc == done_cyc) begin
            exp_rv[m_grant] = 1'b1;
            exp_err = done_err;
        end
        chk("req_ready", 64'(bif.req_ready_o), 64'(exp_rdy));
        chk("brom_req_valid", 64'(bif.brom_req_valid_o), 64'(exp_bv));
        if (exp_bv) chk("brom_addr", 64'(bif.brom_req_address_o), 64'(m_addr));
        chk("resp_valid", 64'(bif.resp_valid_o), 64'(exp_rv));
        chk("resp_err", 64'(bif.resp_err_o), 64'(exp_err));
        if (|exp_rv) chk("resp_data", 64'(bif.resp_data_o), 64'(done_data));
        // observations used by directed latency checks
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bif.req_ready_o[i] && rv[i]) begin
                last_acc_cyc = cyc; last_acc_idx = i; first_bv_cyc = -1;
                grants.push_back(i);
            end
        end
        if (first_bv_cyc < 0 && bif.brom_req_valid_o) begin
            first_bv_cyc = cyc; first_bv_addr = bif.brom_req_address_o;
        end
        if (|bif.resp_valid_o) begin
            pulses++; last_pulse_cyc = cyc; last_pulse_vec = bif.resp_valid_o;
            last_pulse_data = bif.resp_data_o; last_pulse_err = bif.resp_err_o;
        end
        if (!rst && bif.brom_req_valid_o && rdy) begin
            if (rand_mode) rom_lat = $urandom_range(1, 11);
            if (rom_rand) rom_data = $urandom;
            rom_due = cyc + rom_lat;
        end
        // model state after this clock edge
        if (rst) begin
            tx_active = 0; draining = 0; m_ptr = NUM_REQ - 1; done_cyc = -1;
        end else begin
            if (draining && cyc > done_cyc && rdy && !resp_in) draining = 0;
            if (tx_active && cyc == done_cyc) begin
                m_ptr = m_grant; tx_active = 0;
                if (done_err) draining = 1;
            end else if (tx_active && hs_cyc >= 0 && done_cyc < 0 && cyc > hs_cyc) begin
                if (resp_in) begin
                    done_cyc = cyc + 1; done_data = bif.brom_resp_data_i; done_err = 0;
                end else if (cyc == hs_cyc + TIMEOUT) begin
                    done_cyc = cyc + 1; done_data = '0; done_err = 1;
                end
            end else if (tx_active && hs_cyc < 0 && cyc > acc_cyc && rdy) begin
                hs_cyc = cyc;
            end
            if (w >= 0) begin
                tx_active = 1; acc_cyc = cyc; m_grant = w; m_addr = ra[w];
                hs_cyc = -1; done_cyc = -1;
                if (drop_on_accept || rand_mode) rv[w] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) one_cycle();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) one_cycle();
    endtask

    task automatic wait_acc(input int budget);
        int b;
        b = 0;
        while (last_acc_cyc < 0 && b < budget) begin one_cycle(); b++; end
        if (last_acc_cyc < 0) chk("acceptance_budget", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        rv = '0; rdy = 1'b1; rst = 1'b1;
        run(2);
        rst = 1'b0;
        rom_mute = 0; rom_rand = 0; rom_lat = 5; drop_on_accept = 1;
        clear_obs();
    endtask

    initial begin
        int t;
        rst = 1'b1; rv = '0; rdy = 1'b1; force_resp = 0; rand_mode = 0; drop_on_accept = 1;
        rom_lat = 5; rom_due = -1; rom_mute = 0; rom_rand = 0; rom_data = '0;
        for (int i = 0; i < NUM_REQ; i++) ra[i] = '0;
        bif.req_valid_i = '0; bif.req_addr_i = '0; bif.brom_ready_i = 1'b1;
        bif.brom_resp_valid_i = 1'b0; bif.brom_resp_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0; tx_active = 0; draining = 0; m_ptr = NUM_REQ - 1;
        acc_cyc = -1; hs_cyc = -1; done_cyc = -1; clear_obs();
        // reset state, ready held low while rst is asserted
        bif.req_valid_i = 2'b11;
        #1;
        chk("rst_req_ready", 64'(bif.req_ready_o), 64'(0));
        chk("rst_brom_valid", 64'(bif.brom_req_valid_o), 64'(0));
        chk("rst_brom_addr", 64'(bif.brom_req_address_o), 64'(0));
        chk("rst_resp_valid", 64'(bif.resp_valid_o), 64'(0));
        chk("rst_resp_err", 64'(bif.resp_err_o), 64'(0));
        chk("rst_resp_data", 64'(bif.resp_data_o), 64'(0));
        do_reset();

        // single request with the standard 5-cycle ROM
        rom_data = 32'hDEADBEEF; ra[0] = 24'h000104; rv = 2'b01;
        wait_acc(20);
        t = last_acc_cyc;
        run(10);
        chk("single_grant", 64'(last_acc_idx), 64'(0));
        chk("single_issue_lat", 64'(first_bv_cyc - t), 64'(1));
        chk("single_issue_addr", 64'(first_bv_addr), 64'(24'h000104));
        chk("single_resp_lat", 64'(last_pulse_cyc - t), 64'(7));
        chk("single_resp_vec", 64'(last_pulse_vec), 64'(2'b01));
        chk("single_resp_data", 64'(last_pulse_data), 64'(32'hDEADBEEF));
        chk("single_resp_err", 64'(last_pulse_err), 64'(0));

        // contention: both requesters continuously valid
        do_reset();
        rom_rand = 1; drop_on_accept = 0; rv = 2'b11;
        ra[0] = 24'h000200; ra[1] = 24'h00F000;
        for (int b = 0; b < 200 && grants.size() < 4; b++) one_cycle();
        rv = '0; drop_on_accept = 1;
        run(12);
        chk("contention_count", 64'(grants.size()), 64'(4));
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk($sformatf("contention_grant%0d", k), 64'(grants[k]), 64'(k % 2));
        chk("contention_pulses", 64'(pulses), 64'(4));

        // busy ROM: no grant until ready, then ready drops during issue
        do_reset();
        rdy = 1'b0; rv = 2'b01; ra[0] = 24'h0ABCDE;
        run(3);
        chk("busy_no_accept", 64'(grants.size()), 64'(0));
        rdy = 1'b1;
        t = cyc;
        one_cycle();
        chk("busy_accept_cycle", 64'(last_acc_cyc), 64'(t));
        rdy = 1'b0;
        run(3);
        chk("busy_issue_held", 64'(bif.brom_req_valid_o), 64'(1));
        chk("busy_issue_addr", 64'(bif.brom_req_address_o), 64'(24'h0ABCDE));
        rdy = 1'b1;
        run(10);
        chk("busy_pulses", 64'(pulses), 64'(1));

        // watchdog timeout, then a late response during drain
        do_reset();
        rom_mute = 1; rv = 2'b01; ra[0] = 24'h000040;
        wait_acc(20);
        t = last_acc_cyc;
        run_to(t + 11);
        chk("timeout_lat", 64'(last_pulse_cyc - t), 64'(10));
        chk("timeout_err", 64'(last_pulse_err), 64'(1));
        chk("timeout_data", 64'(last_pulse_data), 64'(0));
        force_resp = 1'b1;
        one_cycle();
        rom_mute = 0;
        run(6);
        chk("timeout_single_pulse", 64'(pulses), 64'(1));

        // reset while waiting for the ROM
        do_reset();
        rom_data = 32'h55AA55AA; rv = 2'b01; ra[1] = 24'h000300;
        wait_acc(20);
        t = last_acc_cyc;
        run_to(t + 3);
        rst = 1'b1;
        one_cycle();
        rst = 1'b0;
        chk("midrst_brom_valid", 64'(bif.brom_req_valid_o), 64'(0));
        chk("midrst_brom_addr", 64'(bif.brom_req_address_o), 64'(0));
        chk("midrst_resp_valid", 64'(bif.resp_valid_o), 64'(0));
        chk("midrst_resp_data", 64'(bif.resp_data_o), 64'(0));
        run_to(t + 12);
        chk("midrst_no_pulse", 64'(pulses), 64'(0));
        last_acc_cyc = -1; rv = 2'b11;
        wait_acc(20);
        chk("midrst_next_grant", 64'(last_acc_idx), 64'(0));
        rv = '0;
        run(12);

        // ROM response on the final watchdog cycle
        do_reset();
        rom_lat = 8; rom_data = 32'h12345678; rv = 2'b01;
        wait_acc(20);
        t = last_acc_cyc;
        run(14);
        chk("race_lat", 64'(last_pulse_cyc - t), 64'(10));
        chk("race_err", 64'(last_pulse_err), 64'(0));
        chk("race_data", 64'(last_pulse_data), 64'(32'h12345678));

        // random traffic, ROM latency and spurious pulses
        do_reset();
        rom_rand = 1; rand_mode = 1;
        run(3000);
        rand_mode = 0; rv = '0; rdy = 1'b1;
        run(30);
        chk("random_idle", 64'(tx_active || draining), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/brom_arbiter.md
Name: brom_arbiter

Overview:
- Shares the single-port boot ROM between NUM_REQ requesters, e.g. core instruction fetch and debug/loader.
- Runs a round-robin grant and drives the boot ROM request/ready/response handshake for one transaction at a time.
- Returns each response only to the requester that issued it.
- Has a watchdog timeout, so a lost response produces an error completion instead of hanging fetch.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_W, 24, request address width; matches the boot ROM address port.
- DATA_W, 32, response data width.
- TIMEOUT, 64, max cycles in WAIT before error completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid; held until accepted.
- req_addr_i  in  NUM_REQ*ADDR_W  per-requester byte address; slice i is [i*ADDR_W +: ADDR_W].
- req_ready_o  out  NUM_REQ  one-hot grant; acceptance = req_valid_i[i] & req_ready_o[i].
- resp_valid_o  out  NUM_REQ  one-hot, one-cycle response pulse to the owning requester.
- resp_err_o  out  1  qualifies resp_valid_o; 1 = timeout completion.
- resp_data_o  out  DATA_W  response data, broadcast, valid only with resp_valid_o.
- brom_req_valid_o  out  1  request to the boot ROM.
- brom_req_address_o  out  ADDR_W  registered address of the granted request.
- brom_ready_i  in  1  boot ROM idle/ready.
- brom_resp_data_i  in  DATA_W  boot ROM read data.
- brom_resp_valid_i  in  1  boot ROM response pulse.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, rr_ptr=NUM_REQ-1, timer=0.
  - Registered outputs after reset: brom_req_valid_o=0, brom_req_address_o=0, resp_valid_o=0, resp_err_o=0, resp_data_o=0.
  - req_ready_o is combinational and is 0 while rst=1.
  - Reset mid-transaction aborts it with no completion pulse. Any later brom_resp_valid_i is discarded, because it arrives in IDLE.
- IDLE:
  - req_ready_o is combinational: the one-hot round-robin winner among req_valid_i, searching from rr_ptr+1 with wrap, only when brom_ready_i=1. Otherwise all zero.
  - On acceptance in cycle T: latch grant index and address, then go to ISSUE.
- ISSUE:
  - brom_req_valid_o=1 (registered), first high in cycle T+1; brom_req_address_o holds the latched address.
  - Leave to WAIT at the first edge where brom_ready_i=1 with brom_req_valid_o=1.
  - If brom_ready_i=0, hold valid and address stable.
  - Clear brom_req_valid_o on exit, so exactly one cycle of valid when ready is already high.
- WAIT:
  - timer increments each cycle starting from 0; all req_ready_o=0.
  - On brom_resp_valid_i=1: register brom_resp_data_i into resp_data_o, go to RESP.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: resp_data_o=0, go to RESP with err flag set.
  - If both happen in the same cycle, the response wins (err=0).
- RESP (one cycle):
  - resp_valid_o[grant]=1, resp_err_o=err.
  - rr_ptr<=grant; this is the only point where rr_ptr updates.
  - If err=0, go to IDLE. If err=1, go to DRAIN.
- DRAIN:
  - Discard any brom_resp_valid_i.
  - Go to IDLE at the first edge where brom_ready_i=1 and brom_resp_valid_i=0.
- Latency:
  - brom_resp_valid_i in cycle T+k gives resp_valid_o in T+k+1.
  - With the standard boot ROM (response 5 cycles after its request cycle), resp_valid_o fires in T+7.
  - A new acceptance is possible in the cycle after RESP.
- Spurious brom_resp_valid_i in IDLE or ISSUE is ignored.
- req_addr_i changes while not accepted have no effect.
- Throughput is one transaction outstanding; requesters never starve. With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- timer width is $clog2(TIMEOUT+1) and it is cleared on entry to WAIT; no wrap is possible.

Test Plan:
- Single request: after reset, req_valid_i=2'b01, addr 0x000104; boot ROM model returns 0xDEADBEEF 5 cycles after its request.
  -> req_ready_o=01 in T; brom_req_valid_o in T+1 with address 0x000104; resp_valid_o=01, data 0xDEADBEEF, err=0 in T+7.
- Contention: both requesters valid continuously for 4 transactions.
  -> grants 0,1,0,1; each resp_valid_o goes to the matching requester only; never two outstanding.
- Busy ROM: brom_ready_i=0 for 3 cycles after reset while req_valid_i=01.
  -> req_ready_o stays 0; acceptance in the first cycle brom_ready_i=1.
  - Variant: drop ready during ISSUE. -> brom_req_valid_o and address hold stable.
- Timeout: TIMEOUT=8, model never responds.
  -> resp_valid_o pulses with err=1 and data 0 in T+10 (WAIT entered at T+2, 8 cycles).
  -> Then DRAIN: a late brom_resp_valid_i is discarded and no second pulse occurs.
- Reset mid-WAIT: assert rst for 1 cycle 2 cycles after issue.
  -> all outputs 0; the subsequent model response produces no resp_valid_o; next grant goes to requester 0.
- Race: brom_resp_valid_i in the same cycle the timer reaches TIMEOUT-1.
  -> normal completion, err=0, data from the ROM.
